gaussian_sample_monitor: RTL

Consumer end of the Gaussian generator output interface: accepts pairs of signed 16-bit Gaussian samples plus a valid strobe. Accumulates a programmed number of samples and reports the estimated mean and variance. Sits downstream of the Box-Muller generator in the flash-channel simulation. On-chip self-check that the programmed mean/standard deviation is actually delivered.

---
 rtl/gsm_pkg.sv | 34 +++
 rtl/gsm_lane_acc.sv | 23 ++
 rtl/gaussian_sample_monitor.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gsm_pkg.sv
// Shared types and constants for the Gaussian sample monitor.
// Optional histogram support is enabled with the GSM_HISTOGRAM_EN macro.
package gsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    MEAN,
    VAR,
    DONE
  } state_t;

  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned SQ_W      = 32;
  localparam int unsigned VAR_W     = 32;
  localparam int unsigned HIST_BINS = 8;
  localparam int          BIN_MIN   = -4;
  localparam int          BIN_MAX   = 3;

  // Histogram bin of one sample: floor of its value, clamped to BIN_MIN..BIN_MAX, offset to 0..7.
  function automatic logic [2:0] bin_index(input logic [SAMPLE_W-1:0] s, input int unsigned frac_w);
    logic signed [SAMPLE_W-1:0] ip;
    int                         ipi;
    ip  = $signed(s) >>> frac_w;
    ipi = int'(ip);
    if (ipi < BIN_MIN) begin
      ipi = BIN_MIN;
    end else if (ipi > BIN_MAX) begin
      ipi = BIN_MAX;
    end
    return 3'(ipi - BIN_MIN);
  endfunction

endpackage

// File: rtl/gsm_lane_acc.sv
// One sample lane: sign-extends the sample to the sum width and forms its square.
module gsm_lane_acc
  import gsm_pkg::*;
#(
  parameter int unsigned EXT_W = 27
) (
  input  logic [SAMPLE_W-1:0] sample,
  output logic [EXT_W-1:0]    sample_ext,
  output logic [SQ_W-1:0]     sample_sq
);

  logic signed [SQ_W-1:0] sample_wide;
  logic signed [SQ_W-1:0] square;

  // Squares of 16-bit signed values never exceed 2^30, so a 32-bit product is exact and non-negative.
  always_comb begin
    sample_wide = {{(SQ_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
    square      = sample_wide * sample_wide;
    sample_sq   = square;
    sample_ext  = {{(EXT_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
  end

endmodule

// File: rtl/gaussian_sample_monitor.sv
// Gaussian sample monitor: accumulates 2^LOG2_N sample pairs, then reports mean and variance.
// Define GSM_HISTOGRAM_EN to add 8 value-range bin counters with a hist_sel/hist_count read port.
module gaussian_sample_monitor
  import gsm_pkg::*;
#(
  parameter int unsigned LOG2_N = 10,
  parameter int unsigned FRAC_W = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sample_valid,
  input  logic [15:0]         sample_a,
  input  logic [15:0]         sample_b,
`ifdef GSM_HISTOGRAM_EN
  input  logic [2:0]          hist_sel,
  output logic [LOG2_N+1:0]   hist_count,
`endif
  output logic                busy,
  output logic                done,
  output logic [15:0]         mean_out,
  output logic [31:0]         var_out,
  output logic [LOG2_N:0]     pair_count
);

  localparam int unsigned SUM_W = SAMPLE_W + LOG2_N + 1;
  localparam int unsigned SSQ_W = SQ_W + LOG2_N + 1;
  localparam int unsigned SHIFT = LOG2_N + 1;
  localparam logic [LOG2_N:0] LAST_PAIR = {1'b0, {LOG2_N{1'b1}}};

  if (LOG2_N < 1 || LOG2_N > 14 || FRAC_W >= SAMPLE_W) begin : g_bad_params
    $error("gaussian_sample_monitor: LOG2_N must be 1..14 and FRAC_W below 16");
  end

  state_t                   state, state_next;
  logic                     accept, begin_meas;
  logic [SUM_W-1:0]         sum, ext_a, ext_b;
  logic [SSQ_W-1:0]         sumsq;
  logic [SQ_W-1:0]          sq_a, sq_b, msq;
  logic signed [SUM_W-1:0]  sum_shift;
  logic [SSQ_W-1:0]         ssq_shift;
  logic signed [SQ_W-1:0]   mean_wide, mean_sq;
  logic [SQ_W+1:0]          var_diff;
  logic [VAR_W-1:0]         var_sat;

  gsm_lane_acc #(.EXT_W(SUM_W)) u_lane_a (
    .sample     (sample_a),
    .sample_ext (ext_a),
    .sample_sq  (sq_a)
  );

  gsm_lane_acc #(.EXT_W(SUM_W)) u_lane_b (
    .sample     (sample_b),
    .sample_ext (ext_b),
    .sample_sq  (sq_b)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state, status outputs and datapath strobes.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    begin_meas = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          begin_meas = 1'b1;
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        busy = 1'b1;
        if (sample_valid) begin
          accept = 1'b1;
          if (pair_count == LAST_PAIR) state_next = MEAN;
        end
      end
      MEAN: begin
        busy       = 1'b1;
        state_next = VAR;
      end
      VAR: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Mean/variance arithmetic; the difference is kept 2 bits wider so borrow and overflow are visible.
  always_comb begin
    sum_shift = $signed(sum) >>> SHIFT;
    ssq_shift = sumsq >> SHIFT;
    mean_wide = {{(SQ_W-SAMPLE_W){mean_out[SAMPLE_W-1]}}, mean_out};
    mean_sq   = mean_wide * mean_wide;
    var_diff  = {2'b00, msq} - {2'b00, mean_sq};
    if (var_diff[SQ_W+1])   var_sat = '0;
    else if (var_diff[SQ_W]) var_sat = '1;
    else                     var_sat = var_diff[VAR_W-1:0];
  end

  // Accumulators and pair counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum        <= '0;
      sumsq      <= '0;
      pair_count <= '0;
    end else if (begin_meas) begin
      sum        <= '0;
      sumsq      <= '0;
      pair_count <= '0;
    end else if (accept) begin
      sum        <= sum + ext_a + ext_b;
      sumsq      <= sumsq + SSQ_W'(sq_a) + SSQ_W'(sq_b);
      pair_count <= pair_count + (LOG2_N+1)'(1);
    end
  end

  // Result registers: mean and mean-square in MEAN, variance in VAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mean_out <= '0;
      msq      <= '0;
      var_out  <= '0;
    end else if (state == MEAN) begin
      mean_out <= sum_shift[SAMPLE_W-1:0];
      msq      <= ssq_shift[SQ_W-1:0];
    end else if (state == VAR) begin
      var_out  <= var_sat;
    end
  end

`ifdef GSM_HISTOGRAM_EN
  logic [LOG2_N+1:0] hist     [HIST_BINS];
  logic [LOG2_N+1:0] hist_inc [HIST_BINS];
  logic [2:0]        bin_a, bin_b;

  // Both lanes are binned every accepted cycle, so a bin may advance by 0, 1 or 2.
  always_comb begin
    bin_a = bin_index(sample_a, FRAC_W);
    bin_b = bin_index(sample_b, FRAC_W);
    for (int unsigned i = 0; i < HIST_BINS; i++) begin
      hist_inc[i] = (LOG2_N+2)'(bin_a == 3'(i)) + (LOG2_N+2)'(bin_b == 3'(i));
    end
    hist_count = hist[hist_sel];
  end

  // Bin counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= '0;
    end else if (begin_meas) begin
      for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < HIST_BINS; i++) hist[i] <= hist[i] + hist_inc[i];
    end
  end
`endif

endmodule
